regr_sample_seq: RTL and testbench

Sample-buffer sequencer for the linear-regression datapath. Collects up to 64 8-bit samples from an upstream loader into an internal 64×8 array, then on command streams the stored samples, in address order, to the regression compute engine. Each stream repeats PASSES times, e.g. a mean pass and a variance pass. It owns all sequencing of the sample store: write pointer, read pointer, pass count and the load/stream phase.

---
 rtl/regr_sample_seq.sv | 166 ++++++++++++++++
 tb/tb_regr_sample_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regr_sample_seq.sv
// Sample-buffer sequencer: loads up to DEPTH samples, then streams them in
// address order PASSES times to the regression engine through a one-entry output register.
module regr_sample_seq #(
  parameter  int DEPTH  = 64,
  parameter  int PASSES = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [7:0]    in_data_i,
  output logic          in_ready_o,
  input  logic          clear_i,
  input  logic          start_i,
  output logic          out_valid_o,
  output logic [7:0]    out_data_o,
  output logic          out_last_o,
  output logic [1:0]    out_pass_o,
  input  logic          out_ready_i,
  output logic [CW-1:0] count_o,
  output logic          busy_o,
  output logic          done_o
);

  // state  | meaning
  // LOAD   | accepting writes, clear and start
  // STREAM | replaying stored samples PASSES times
  // DONE   | one-cycle done pulse, then back to LOAD
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]    pass_q, pass_d;
  logic          fetch_done_q, fetch_done_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [1:0]    out_pass_q, out_pass_d;

  logic [7:0]    mem_q [DEPTH];

  logic          in_ready;
  logic          wr_en;
  logic          out_fire;
  logic          load_en;
  logic          rd_at_last;
  logic          pass_is_final;

  assign in_ready      = (state_q == ST_LOAD) && (count_q < CW'(DEPTH));
  assign wr_en         = in_ready && in_valid_i && !clear_i;
  assign out_fire      = out_valid_q && out_ready_i;
  assign load_en       = (state_q == ST_STREAM) && !fetch_done_q && (!out_valid_q || out_ready_i);
  assign rd_at_last    = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));
  assign pass_is_final = (pass_q == 2'(PASSES - 1));

  // Storage is deliberately left out of reset; only the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[count_q[AW-1:0]] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_LOAD;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      pass_q       <= '0;
      fetch_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_pass_q   <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      pass_q       <= pass_d;
      fetch_done_q <= fetch_done_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_pass_q   <= out_pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    pass_d       = pass_q;
    fetch_done_d = fetch_done_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_pass_d   = out_pass_q;

    unique case (state_q)
      ST_LOAD: begin
        if (clear_i) begin
          count_d = '0;
        end else begin
          if (wr_en) begin
            count_d = count_q + CW'(1);
          end
          // A write landing in the same cycle counts toward the stream length.
          if (start_i && ((count_q != '0) || wr_en)) begin
            state_d      = ST_STREAM;
            rd_ptr_d     = '0;
            pass_d       = '0;
            fetch_done_d = 1'b0;
          end
        end
      end

      ST_STREAM: begin
        if (load_en) begin
          out_valid_d = 1'b1;
          out_data_d  = mem_q[rd_ptr_q];
          out_last_d  = rd_at_last;
          out_pass_d  = pass_q;
          if (rd_at_last) begin
            rd_ptr_d = '0;
            if (pass_is_final) begin
              fetch_done_d = 1'b1;
            end else begin
              pass_d = pass_q + 2'd1;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end else if (out_fire) begin
          out_valid_d = 1'b0;
        end

        if (out_fire && out_last_q && (out_pass_q == 2'(PASSES - 1))) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_LOAD;
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_pass_o  = out_pass_q;
  assign count_o     = count_q;
  assign busy_o      = (state_q == ST_STREAM);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_regr_sample_seq.sv
// Scoreboard bench for regr_sample_seq: directed loads/streams push expected beats,
// a negedge monitor pops and compares every output handshake.
module tb_regr_sample_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       clear;
  logic       start;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] out_pass;
  logic       out_ready;
  logic [6:0] count;
  logic       busy;
  logic       done;

  regr_sample_seq #(.DEPTH(64), .PASSES(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .clear_i    (clear),
    .start_i    (start),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .out_pass_o (out_pass),
    .out_ready_i(out_ready),
    .count_o    (count),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [1:0] p;
  } beat_t;

  beat_t      exp_q [$];
  logic [7:0] model [$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < model.size(); i++) begin
        beat_t b;
        b.d = model[i];
        b.l = (i == model.size() - 1);
        b.p = 2'(p);
        exp_q.push_back(b);
      end
  endtask

  task automatic write(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
    if (model.size() < 64) model.push_back(v);
  endtask

  // mode 0: out_ready always high; mode 1: ready pattern 1,0,0 repeating
  task automatic run_stream(input bit do_start, input int mode, input int exp_valid);
    int vc;
    bit seen;
    vc   = 0;
    seen = 0;
    push_expected();
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("busy_on_start", busy, 1);
    for (int c = 0; c < 400 && !seen; c++) begin
      out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      @(negedge clk);
      if (out_valid) vc++;
      @(posedge clk);
      #1;
      if (c == 0) check("start_latency_valid", out_valid, 1);
      if (done) seen = 1;
    end
    out_ready = 1'b0;
    check("done_seen", seen, 1);
    if (exp_valid > 0) check("valid_cycles", vc, exp_valid);
    check("queue_drained", exp_q.size(), 0);
    tick();
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("in_ready_after_done", in_ready, (model.size() < 64) ? 1 : 0);
    check("count_retained", count, model.size());
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model.delete();
    check("count_after_clear", count, 0);
  endtask

  // Monitor: compare each handshake against the scoreboard and check stall stability.
  logic       held_v = 1'b0;
  logic [7:0] held_d;
  logic       held_l;
  logic [1:0] held_p;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) begin
        check("stall_data_stable", out_data, held_d);
        check("stall_last_stable", out_last, held_l);
        check("stall_pass_stable", out_pass, held_p);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_data", out_data, b.d);
          check("beat_last", out_last, b.l);
          check("beat_pass", out_pass, b.p);
        end
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      held_p = out_pass;
    end
  end

  initial begin
    bit hit;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_pass", out_pass, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Basic
    write(8'd10); write(8'd20); write(8'd30); write(8'd40); write(8'd50);
    check("basic_count", count, 5);
    run_stream(1, 0, 10);

    // Re-stream without loading, then append at address count
    run_stream(1, 0, 10);
    write(8'd60);
    check("append_count", count, 6);
    run_stream(1, 0, 12);
    do_clear();

    // Full buffer: offer 70 writes
    in_valid = 1'b1;
    for (int i = 0; i < 70; i++) begin
      if (i == 64) begin
        check("full_count", count, 64);
        check("full_in_ready", in_ready, 0);
      end
      in_data = 8'(i);
      tick();
      if (model.size() < 64) model.push_back(8'(i));
    end
    in_valid = 1'b0;
    check("full_count_after_70", count, 64);
    run_stream(1, 0, 128);
    do_clear();

    // Back-pressure
    write(8'd7); write(8'd8); write(8'd9);
    run_stream(1, 1, 0);
    do_clear();

    // start with empty buffer
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_start_busy", busy, 0);
    tick();
    check("empty_start_busy_later", busy, 0);
    check("empty_start_valid", out_valid, 0);

    // start together with a write
    write(8'h11); write(8'h22);
    in_valid = 1'b1;
    in_data  = 8'h55;
    start    = 1'b1;
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
    model.push_back(8'h55);
    check("start_wr_count", count, 3);
    run_stream(0, 0, 6);

    // clear together with start, then clear together with a write
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    model.delete();
    check("clear_start_count", count, 0);
    check("clear_start_busy", busy, 0);
    tick();
    check("clear_start_busy_later", busy, 0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_wr_count", count, 0);

    // Reset mid-stream at pass 1, sample 2
    write(8'd1); write(8'd2); write(8'd3); write(8'd4);
    push_expected();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      tick();
      if (out_valid && out_pass == 2'd1 && out_data == 8'd3) hit = 1;
    end
    check("midstream_reached", hit, 1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_count", count, 0);
    exp_q.delete();
    model.delete();
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    write(8'hAA);
    run_stream(1, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
